// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package     : cpu_pkg                                                |
// | Description : Definitions shared by the control unit and the ALU:    |
// |               op_select codes, flag-vector bit positions, the ALU    |
// |               FSM state type and an iterative-op classifier.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package cpu_pkg;

    // op_select encoding, identical to what the control unit drives
    localparam logic [4:0] OP_ADD      = 5'd1;
    localparam logic [4:0] OP_SUB      = 5'd2;
    localparam logic [4:0] OP_LSL      = 5'd3;
    localparam logic [4:0] OP_LSR      = 5'd4;
    localparam logic [4:0] OP_RSL      = 5'd5;
    localparam logic [4:0] OP_RSR      = 5'd6;
    localparam logic [4:0] OP_MUL      = 5'd7;
    localparam logic [4:0] OP_DIV      = 5'd8;
    localparam logic [4:0] OP_MOD      = 5'd9;
    localparam logic [4:0] OP_AND      = 5'd10;
    localparam logic [4:0] OP_OR       = 5'd11;
    localparam logic [4:0] OP_XOR      = 5'd12;
    localparam logic [4:0] OP_NOT      = 5'd13;
    localparam logic [4:0] OP_INC      = 5'd14;
    localparam logic [4:0] OP_DEC      = 5'd15;
    localparam logic [4:0] OP_ADDR_INC = 5'd16;
    localparam logic [4:0] OP_PASS     = 5'd17;
    localparam logic [4:0] OP_CMP      = 5'd18;
    localparam logic [4:0] OP_POW      = 5'd19;
    localparam logic [4:0] OP_LOG2     = 5'd20;
    localparam logic [4:0] OP_LOG10    = 5'd21;
    localparam logic [4:0] OP_SQRT     = 5'd22;

    // Bit positions inside the {Z,N,C,V} flag vector
    localparam logic [1:0] FLAG_Z = 2'd3;
    localparam logic [1:0] FLAG_N = 2'd2;
    localparam logic [1:0] FLAG_C = 2'd1;
    localparam logic [1:0] FLAG_V = 2'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ops that run through the multi-cycle RUN state
    function automatic logic op_is_iterative(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD) ||
               (op == OP_POW) || (op == OP_SQRT);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface   : alu_exec_if                                            |
// | Description : Request/response bundle between control unit (master) |
// |               and execution ALU (slave).                             |
// |   start_i, op_select_i, a_i, b_i : request, driven by the master     |
// |   busy_o, done_o, result_o, flags_o, illegal_o : ALU response        |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface alu_exec_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic [4:0]       op_select_i;
    logic [WIDTH-1:0] a_i;
    logic [WIDTH-1:0] b_i;
    logic             busy_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    logic [3:0]       flags_o;
    logic             illegal_o;

    modport master (
        output start_i, op_select_i, a_i, b_i,
        input  busy_o, done_o, result_o, flags_o, illegal_o
    );

    modport slave (
        input  start_i, op_select_i, a_i, b_i,
        output busy_o, done_o, result_o, flags_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/alu_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_divider                                            |
// | Description : One restoring-division step (one quotient bit).        |
// |   i_rem     : partial remainder                                      |
// |   i_quo     : dividend bits still to consume (MSB first); quotient   |
// |               bits shift in at the LSB                               |
// |   i_divisor : divisor                                                |
// |   o_rem, o_quo : values after this step                              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_divider #(
    parameter int WIDTH = 16
) (
    input  wire  [WIDTH-1:0] i_rem,
    input  wire  [WIDTH-1:0] i_quo,
    input  wire  [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_trial;

    // The extra top bit of w_trial is the borrow: set means "restore".
    // A zero divisor never borrows, giving an all-ones quotient and rem = A.
    assign w_shifted = {i_rem, i_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, i_divisor};
    assign o_rem     = w_trial[WIDTH] ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign o_quo     = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};
endmodule
`default_nettype wire

// File: rtl/alu_exec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : alu_exec                                               |
// | Description : Execution-stage ALU. Single-cycle ops finish in one    |
// |               cycle; MUL/DIV/MOD/POW/SQRT iterate in RUN. Holds the  |
// |               {Z,N,C,V} flags register, written only on done.        |
// |   clk, rst : clock, synchronous active-high reset                    |
// |   bus      : alu_exec_if slave (start/op/operands in, busy/done/     |
// |              result/flags/illegal out)                               |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module alu_exec
    import cpu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire       clk,
    input  wire       rst,
    alu_exec_if.slave bus
);
    localparam int c_CW = $clog2(WIDTH);

    state_t             r_state;
    logic               r_busy, r_done, r_ill;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic [4:0]         r_op;
    logic [c_CW-1:0]    r_cnt;
    logic [WIDTH-1:0]   r_opa;          // multiplier / dividend-quotient / exponent / radicand
    logic [2*WIDTH-1:0] r_acc, r_mcand; // MUL accumulator and shifted multiplicand
    logic [WIDTH+1:0]   r_rem;          // DIV and SQRT partial remainder
    logic [WIDTH-1:0]   r_root, r_divisor, r_pow_res, r_pow_base;
    logic               r_bzero, r_pow_ovf, r_base_ovf;

    logic [WIDTH-1:0]   w_a, w_b;
    logic [3:0]         w_sh;
    assign w_a  = bus.a_i;
    assign w_b  = bus.b_i;
    assign w_sh = w_b[3:0];

    function automatic logic [3:0] pack_flags(input logic [WIDTH-1:0] res, input logic c, input logic v);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (res == '0);
        f[FLAG_N] = res[WIDTH-1];
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH:0]   w_sum, w_diff, w_inc, w_dec, w_lsl, w_lsr;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v, w_upd, w_ill;
    logic [WIDTH+15:0] w_a_ext;

    assign w_sum   = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff  = {1'b0, w_a} - {1'b0, w_b};
    assign w_inc   = {1'b0, w_a} + (WIDTH+1)'(1);
    assign w_dec   = {1'b0, w_a} - (WIDTH+1)'(1);
    // Extra bit catches the last bit shifted out (stays 0 for a zero shift)
    assign w_lsl   = {1'b0, w_a} << w_sh;
    assign w_lsr   = {w_a, 1'b0} >> w_sh;
    assign w_a_ext = {16'b0, w_a};

    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_upd = 1'b1;
        w_ill = 1'b0;
        case (bus.op_select_i)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                w_res = (bus.op_select_i == OP_CMP) ? w_a : w_diff[WIDTH-1:0];
                w_c   = w_diff[WIDTH];
                w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            OP_LSL:  begin w_res = w_lsl[WIDTH-1:0]; w_c = w_lsl[WIDTH]; end
            OP_LSR:  begin w_res = w_lsr[WIDTH:1];   w_c = w_lsr[0];     end
            OP_RSL:  w_res = (w_a << w_sh) | (w_a >> (WIDTH - int'(w_sh)));
            OP_RSR:  w_res = (w_a >> w_sh) | (w_a << (WIDTH - int'(w_sh)));
            OP_AND:  w_res = w_a & w_b;
            OP_OR:   w_res = w_a | w_b;
            OP_XOR:  w_res = w_a ^ w_b;
            OP_NOT:  w_res = ~w_a;
            OP_INC: begin
                w_res = w_inc[WIDTH-1:0];
                w_c   = w_inc[WIDTH];
                w_v   = ~w_a[WIDTH-1] & w_res[WIDTH-1];
            end
            OP_DEC: begin
                w_res = w_dec[WIDTH-1:0];
                w_c   = w_dec[WIDTH];
                w_v   = w_a[WIDTH-1] & ~w_res[WIDTH-1];
            end
            OP_ADDR_INC: begin w_res = w_inc[WIDTH-1:0]; w_upd = 1'b0; end
            OP_PASS:     begin w_res = w_b;              w_upd = 1'b0; end
            OP_LOG2: begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (w_a[i]) w_res = WIDTH'(i);
                end
                w_v = (w_a == '0);
            end
            OP_LOG10: begin
                if (w_a_ext >= (WIDTH+16)'(10))    w_res = WIDTH'(1);
                if (w_a_ext >= (WIDTH+16)'(100))   w_res = WIDTH'(2);
                if (w_a_ext >= (WIDTH+16)'(1000))  w_res = WIDTH'(3);
                if (w_a_ext >= (WIDTH+16)'(10000)) w_res = WIDTH'(4);
                w_v = (w_a == '0);
            end
            OP_MUL, OP_DIV, OP_MOD, OP_POW, OP_SQRT: w_upd = 1'b0;
            default: begin w_upd = 1'b0; w_ill = 1'b1; end
        endcase
    end

    // ---------------- iterative step datapath ----------------
    logic [2*WIDTH-1:0] w_acc_nxt, w_pow_prod, w_pow_sq;
    logic [WIDTH-1:0]   w_div_rem, w_div_quo, w_pow_res_nxt, w_root_nxt;
    logic               w_pow_ovf_nxt, w_base_ovf_nxt, w_sq_ge;
    logic [WIDTH+1:0]   w_sq_sh, w_sq_trial, w_sq_rem_nxt;

    alu_divider #(.WIDTH(WIDTH)) u_divider (
        .i_rem     (r_rem[WIDTH-1:0]),
        .i_quo     (r_opa),
        .i_divisor (r_divisor),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_acc_nxt  = r_opa[0] ? (r_acc + r_mcand) : r_acc;
    assign w_pow_prod = {{WIDTH{1'b0}}, r_pow_res}  * {{WIDTH{1'b0}}, r_pow_base};
    assign w_pow_sq   = {{WIDTH{1'b0}}, r_pow_base} * {{WIDTH{1'b0}}, r_pow_base};
    assign w_pow_res_nxt = r_opa[0] ? w_pow_prod[WIDTH-1:0] : r_pow_res;
    // r_base_ovf marks a base whose true value no longer fits; multiplying it
    // into the result is an overflow even if the truncated product looks small.
    assign w_pow_ovf_nxt  = r_pow_ovf | (r_opa[0] & ((w_pow_prod[2*WIDTH-1:WIDTH] != '0) | r_base_ovf));
    assign w_base_ovf_nxt = r_base_ovf | (w_pow_sq[2*WIDTH-1:WIDTH] != '0);

    // Digit-by-digit root: bring down two radicand bits, try (root<<2)|1
    assign w_sq_sh      = (r_rem << 2) | {{WIDTH{1'b0}}, r_opa[WIDTH-1 -: 2]};
    assign w_sq_trial   = {r_root, 2'b01};
    assign w_sq_ge      = (w_sq_sh >= w_sq_trial);
    assign w_sq_rem_nxt = w_sq_ge ? (w_sq_sh - w_sq_trial) : w_sq_sh;
    assign w_root_nxt   = (r_root << 1) | {{(WIDTH-1){1'b0}}, w_sq_ge};

    logic [WIDTH-1:0] w_fin_res;
    logic             w_fin_c, w_fin_v;
    always_comb begin
        w_fin_res = w_root_nxt;
        w_fin_c   = 1'b0;
        w_fin_v   = 1'b0;
        case (r_op)
            OP_MUL: begin
                w_fin_res = w_acc_nxt[WIDTH-1:0];
                w_fin_c   = (w_acc_nxt[2*WIDTH-1:WIDTH] != '0);
                w_fin_v   = w_fin_c;
            end
            OP_DIV: begin w_fin_res = w_div_quo; w_fin_v = r_bzero; end
            OP_MOD: begin w_fin_res = w_div_rem; w_fin_v = r_bzero; end
            OP_POW: begin w_fin_res = w_pow_res_nxt; w_fin_v = w_pow_ovf_nxt; end
            default: ;
        endcase
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ill      <= 1'b0;
            r_result   <= '0;
            r_flags    <= '0;
            r_op       <= '0;
            r_cnt      <= '0;
            r_opa      <= '0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_rem      <= '0;
            r_root     <= '0;
            r_divisor  <= '0;
            r_bzero    <= 1'b0;
            r_pow_res  <= '0;
            r_pow_base <= '0;
            r_pow_ovf  <= 1'b0;
            r_base_ovf <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_ill  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (bus.start_i) begin
                        r_op <= bus.op_select_i;
                        if (op_is_iterative(bus.op_select_i)) begin
                            r_state    <= RUN;
                            r_busy     <= 1'b1;
                            r_cnt      <= (bus.op_select_i == OP_SQRT) ? c_CW'(WIDTH/2 - 1) : c_CW'(WIDTH - 1);
                            r_opa      <= ((bus.op_select_i == OP_MUL) || (bus.op_select_i == OP_POW)) ? w_b : w_a;
                            r_acc      <= '0;
                            r_mcand    <= {{WIDTH{1'b0}}, w_a};
                            r_rem      <= '0;
                            r_root     <= '0;
                            r_divisor  <= w_b;
                            r_bzero    <= (w_b == '0);
                            r_pow_res  <= WIDTH'(1);
                            r_pow_base <= w_a;
                            r_pow_ovf  <= 1'b0;
                            r_base_ovf <= 1'b0;
                        end else begin
                            r_state  <= DONE;
                            r_done   <= 1'b1;
                            r_ill    <= w_ill;
                            r_result <= w_res;
                            if (w_upd) r_flags <= pack_flags(w_res, w_c, w_v);
                        end
                    end
                end
                RUN: begin
                    case (r_op)
                        OP_MUL: begin
                            r_acc   <= w_acc_nxt;
                            r_mcand <= r_mcand << 1;
                            r_opa   <= r_opa >> 1;
                        end
                        OP_DIV, OP_MOD: begin
                            r_rem <= {2'b00, w_div_rem};
                            r_opa <= w_div_quo;
                        end
                        OP_POW: begin
                            r_pow_res  <= w_pow_res_nxt;
                            r_pow_base <= w_pow_sq[WIDTH-1:0];
                            r_pow_ovf  <= w_pow_ovf_nxt;
                            r_base_ovf <= w_base_ovf_nxt;
                            r_opa      <= r_opa >> 1;
                        end
                        default: begin
                            r_rem  <= w_sq_rem_nxt;
                            r_root <= w_root_nxt;
                            r_opa  <= r_opa << 2;
                        end
                    endcase
                    if (r_cnt == '0) begin
                        r_state  <= DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_result <= w_fin_res;
                        r_flags  <= pack_flags(w_fin_res, w_fin_c, w_fin_v);
                    end else begin
                        r_cnt <= r_cnt - c_CW'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy_o    = r_busy;
    assign bus.done_o    = r_done;
    assign bus.result_o  = r_result;
    assign bus.flags_o   = r_flags;
    assign bus.illegal_o = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_alu_exec                                            |
// | Description : Self-checking bench for alu_exec: directed scenarios   |
// |               followed by random ops against an arithmetic model.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_alu_exec;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_exec_if #(.WIDTH(W)) bus ();
    alu_exec #(.WIDTH(W)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    int         n_checks = 0;
    int         n_errors = 0;
    logic [3:0] m_flags;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the op definitions.
    task automatic model_op(input int op, input int a, input int b, input logic [3:0] fl_in,
                            output int res, output logic [3:0] fl, output bit ill, output int lat);
        longint x;
        int     n, sa, sb, s;
        bit     c, v, upd;
        c = 0; v = 0; upd = 1; ill = 0; res = 0;
        n  = b % 16;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        lat = (op == 7 || op == 8 || op == 9 || op == 19) ? 17 : (op == 22) ? 9 : 1;
        case (op)
            1:  begin res = (a + b) % 65536; c = (a + b) > 65535; s = sa + sb; v = (s > 32767) || (s < -32768); end
            2, 18: begin
                res = (op == 18) ? a : (a - b + 65536) % 65536;
                c = a < b; s = sa - sb; v = (s > 32767) || (s < -32768);
            end
            3:  begin res = (a << n) % 65536; c = (n != 0) && (((a >> (16 - n)) & 1) == 1); end
            4:  begin res = a >> n; c = (n != 0) && (((a >> (n - 1)) & 1) == 1); end
            5:  begin res = a; repeat (n) res = ((res << 1) | (res >> 15)) & 65535; end
            6:  begin res = a; repeat (n) res = (res >> 1) | ((res & 1) << 15); end
            7:  begin x = longint'(a) * b; res = int'(x % 65536); c = x > 65535; v = c; end
            8:  begin res = (b == 0) ? 65535 : a / b; v = (b == 0); end
            9:  begin res = (b == 0) ? a : a % b;     v = (b == 0); end
            10: res = a & b;
            11: res = a | b;
            12: res = a ^ b;
            13: res = 65535 - a;
            14: begin res = (a + 1) % 65536; c = (a == 65535); v = (a == 32767); end
            15: begin res = (a + 65535) % 65536; c = (a == 0); v = (a == 32768); end
            16: begin res = (a + 1) % 65536; upd = 0; end
            17: begin res = b; upd = 0; end
            19: begin
                x = 1; res = 1;
                repeat (b) begin
                    res = int'((longint'(res) * a) % 65536);
                    x = x * a;
                    if (x > 65535) x = 65536;
                end
                v = (x > 65535);
            end
            20: if (a == 0) v = 1; else while ((1 << (res + 1)) <= a) res++;
            21: if (a == 0) v = 1; else begin x = 10; while (x <= a) begin res++; x = x * 10; end end
            22: while ((res + 1) * (res + 1) <= a) res++;
            default: begin ill = 1; upd = 0; end
        endcase
        fl = upd ? {res == 0, ((res >> 15) & 1) == 1, c, v} : fl_in;
    endtask

    task automatic run_op(input int op, input int a, input int b, input bit poke, input bit gap);
        int         e_res, e_lat, cyc;
        logic [3:0] e_fl;
        bit         e_ill, busy_first;
        model_op(op, a, b, m_flags, e_res, e_fl, e_ill, e_lat);
        bus.start_i     = 1'b1;
        bus.op_select_i = 5'(op);
        bus.a_i         = 16'(a);
        bus.b_i         = 16'(b);
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        bus.a_i     = 16'($urandom);
        bus.b_i     = 16'($urandom);
        busy_first  = bus.busy_o;
        cyc = 1;
        while (!bus.done_o && cyc < 40) begin
            if (poke && cyc == 4) begin
                bus.start_i     = 1'b1;
                bus.op_select_i = 5'd1;
            end
            @(posedge clk); #1;
            bus.start_i = 1'b0;
            cyc++;
        end
        check_eq($sformatf("busy op%0d", op), 32'(busy_first), 32'(e_lat > 1));
        check_eq($sformatf("latency op%0d", op), cyc, e_lat);
        check_eq($sformatf("result op%0d a=%0h b=%0h", op, a, b), 32'(bus.result_o), e_res);
        check_eq($sformatf("flags op%0d a=%0h b=%0h", op, a, b), 32'(bus.flags_o), 32'(e_fl));
        check_eq($sformatf("illegal op%0d", op), 32'(bus.illegal_o), 32'(e_ill));
        check_eq($sformatf("busy_at_done op%0d", op), 32'(bus.busy_o), 0);
        m_flags = e_fl;
        if (gap) begin
            @(posedge clk); #1;
            check_eq("done_single_pulse", 32'(bus.done_o), 0);
            check_eq("illegal_single_pulse", 32'(bus.illegal_o), 0);
        end
    endtask

    function automatic int rnd_word();
        case ($urandom_range(0, 7))
            0: return 0;
            1: return 65535;
            2: return 32768;
            3: return 32767;
            4: return 1;
            default: return int'($urandom_range(0, 65535));
        endcase
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.op_select_i = 5'd0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        m_flags         = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset result", 32'(bus.result_o), 0);
        check_eq("reset flags", 32'(bus.flags_o), 0);
        check_eq("reset busy", 32'(bus.busy_o), 0);
        check_eq("reset done", 32'(bus.done_o), 0);
        check_eq("reset illegal", 32'(bus.illegal_o), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed scenarios
        run_op(1, 16'h7FFF, 1, 0, 1);
        run_op(7, 300, 300, 1, 0);
        run_op(8, 100, 7, 0, 0);
        run_op(9, 100, 7, 0, 1);
        run_op(8, 5, 0, 0, 0);
        run_op(9, 5, 0, 0, 0);
        run_op(22, 1000, 0, 0, 1);
        run_op(20, 1024, 0, 0, 0);
        run_op(21, 0, 0, 0, 0);
        run_op(18, 5, 5, 0, 0);
        run_op(17, 1234, 77, 0, 0);
        run_op(25, 9, 9, 0, 1);
        run_op(3, 16'h8001, 1, 0, 0);
        run_op(4, 16'h0003, 0, 0, 0);
        run_op(19, 2, 16, 0, 1);

        // Reset while POW is running: aborted with no done
        bus.start_i     = 1'b1;
        bus.op_select_i = 5'd19;
        bus.a_i         = 16'd3;
        bus.b_i         = 16'd5;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("abort busy", 32'(bus.busy_o), 0);
        check_eq("abort done", 32'(bus.done_o), 0);
        check_eq("abort result", 32'(bus.result_o), 0);
        check_eq("abort flags", 32'(bus.flags_o), 0);
        m_flags  = 4'h0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.done_o) saw_done = 1'b1;
        end
        check_eq("abort no_done", 32'(saw_done), 0);
        run_op(19, 3, 5, 0, 1);

        // Random ops, mixing back-to-back issue and idle gaps
        repeat (300) begin
            run_op(int'($urandom_range(0, 31)), rnd_word(), rnd_word(),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
